// File: rtl/mmio_port_responder_pkg.sv
// Register map, control/status bit positions and reset values shared by the
// MMIO port responder, its bus interface and its PortIn synchronizer.
package mmio_defs;

   localparam int DATA_W = 32;

   // Word offsets, taken from Address[4:2]
   localparam logic [2:0] OFS_PORTOUT = 3'd0;
   localparam logic [2:0] OFS_PORTIN  = 3'd1;
   localparam logic [2:0] OFS_CONTROL = 3'd2;
   localparam logic [2:0] OFS_STATUS  = 3'd3;
   localparam logic [2:0] OFS_TCOUNT  = 3'd4;
   localparam logic [2:0] OFS_TCMP    = 3'd5;

   localparam int CTL_TEN      = 0;
   localparam int CTL_AUTOCLR  = 1;
   localparam int CTL_IE_CHG   = 2;
   localparam int CTL_IE_MATCH = 3;

   localparam int STS_CHG   = 0;
   localparam int STS_MATCH = 1;

   // Field order puts TEN at bit 0 when the struct is viewed as CONTROL[3:0]
   typedef struct packed {
      logic ie_match;
      logic ie_chg;
      logic autoclr;
      logic ten;
   } ctrl_t;

   localparam logic [DATA_W-1:0] RST_PORTOUT = '0;
   localparam ctrl_t             RST_CONTROL = '0;
   localparam logic [1:0]        RST_STATUS  = '0;
   localparam logic [DATA_W-1:0] RST_TCOUNT  = '0;
   localparam logic [DATA_W-1:0] RST_TCMP    = 32'hFFFF_FFFF;

   function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
      return {{(DATA_W-4){1'b0}}, c};
   endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus as seen by the MMIO responder: the memory stage drives the
// address/strobes (master), the responder returns Hit and ReadData (slave).
interface mmio_port_responder_if;
   import mmio_defs::*;

   logic [DATA_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic              MemWrite;
   logic              MemRead;
   logic [DATA_W-1:0] ReadData;
   logic              Hit;

   modport master (
      output Address,
      output WriteData,
      output MemWrite,
      output MemRead,
      input  ReadData,
      input  Hit
   );

   modport slave (
      input  Address,
      input  WriteData,
      input  MemWrite,
      input  MemRead,
      output ReadData,
      output Hit
   );

endinterface

// File: rtl/mmio_port_responder_port_in_sync.sv
// Two-flop synchronizer for the asynchronous PortIn pins, plus a third flop
// holding the previous synchronized value so a change can be flagged.
module port_in_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync,
   output logic             o_chg_pulse
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_sync      = r_s2;
   assign o_chg_pulse = (r_s2 != r_s3);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target on the data-memory bus: PortOut register, synchronized PortIn
// with sticky change flag, 32-bit compare timer and a level interrupt.
module mmio_port_responder
   import mmio_defs::*;
#(
   parameter logic [31:0] IO_BASE      = 32'hFFFF_0000,
   parameter int          PORTIN_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   mmio_port_responder_if.slave    bus,
   input  logic [PORTIN_WIDTH-1:0] PortIn,
   output logic [DATA_W-1:0]       PortOut,
   output logic                    Irq
);

   logic [DATA_W-1:0] r_portout;
   ctrl_t             r_ctrl;
   logic [1:0]        r_status;
   logic [DATA_W-1:0] r_tcount;
   logic [DATA_W-1:0] r_tcmp;

   logic                    w_hit;
   logic [2:0]              w_ofs;
   logic                    w_wr;
   logic                    w_wr_portout;
   logic                    w_wr_control;
   logic                    w_wr_status;
   logic                    w_wr_tcount;
   logic                    w_wr_tcmp;
   logic [PORTIN_WIDTH-1:0] w_sync;
   logic                    w_chg_pulse;
   logic                    w_tmatch;
   logic [DATA_W-1:0]       w_tcount_nxt;
   logic [1:0]              w_status_set;
   logic [1:0]              w_status_clr;
   logic [1:0]              w_status_nxt;
   logic [DATA_W-1:0]       w_rdata;
   logic                    w_unused_addr;

   port_in_sync #(
      .WIDTH (PORTIN_WIDTH)
   ) u_port_in_sync (
      .clk         (clk),
      .reset       (reset),
      .i_async     (PortIn),
      .o_sync      (w_sync),
      .o_chg_pulse (w_chg_pulse)
   );

   // Word access only; the byte lane bits carry no meaning here
   assign w_unused_addr = ^bus.Address[1:0];

   assign w_hit = (bus.Address[31:5] == IO_BASE[31:5]);
   assign w_ofs = bus.Address[4:2];
   assign w_wr  = w_hit & bus.MemWrite;

   assign w_wr_portout = w_wr && (w_ofs == OFS_PORTOUT);
   assign w_wr_control = w_wr && (w_ofs == OFS_CONTROL);
   assign w_wr_status  = w_wr && (w_ofs == OFS_STATUS);
   assign w_wr_tcount  = w_wr && (w_ofs == OFS_TCOUNT);
   assign w_wr_tcmp    = w_wr && (w_ofs == OFS_TCMP);

   assign w_tmatch = r_ctrl.ten && (r_tcount == r_tcmp);

   // A software store to TCOUNT overrides the increment/auto-clear
   always_comb begin
      w_tcount_nxt = r_tcount;
      if (w_wr_tcount) begin
         w_tcount_nxt = bus.WriteData;
      end else if (r_ctrl.ten) begin
         if (w_tmatch && r_ctrl.autoclr) begin
            w_tcount_nxt = '0;
         end else begin
            w_tcount_nxt = r_tcount + 32'd1;
         end
      end
   end

   // Hardware sets are OR-ed in after the W1C so a coincident set survives
   always_comb begin
      w_status_set            = '0;
      w_status_set[STS_CHG]   = w_chg_pulse;
      w_status_set[STS_MATCH] = w_tmatch;
      w_status_clr            = w_wr_status ? bus.WriteData[1:0] : 2'b00;
      w_status_nxt            = (r_status & ~w_status_clr) | w_status_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_portout <= RST_PORTOUT;
         r_ctrl    <= RST_CONTROL;
         r_status  <= RST_STATUS;
         r_tcount  <= RST_TCOUNT;
         r_tcmp    <= RST_TCMP;
      end else begin
         if (w_wr_portout) r_portout <= bus.WriteData;
         if (w_wr_control) r_ctrl    <= ctrl_t'(bus.WriteData[3:0]);
         if (w_wr_tcmp)    r_tcmp    <= bus.WriteData;
         r_status <= w_status_nxt;
         r_tcount <= w_tcount_nxt;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_hit && bus.MemRead) begin
         case (w_ofs)
            OFS_PORTOUT: w_rdata = r_portout;
            OFS_PORTIN:  w_rdata = DATA_W'(w_sync);
            OFS_CONTROL: w_rdata = ctrl_to_word(r_ctrl);
            OFS_STATUS:  w_rdata = {{(DATA_W-2){1'b0}}, r_status};
            OFS_TCOUNT:  w_rdata = r_tcount;
            OFS_TCMP:    w_rdata = r_tcmp;
            default:     w_rdata = '0;
         endcase
      end
   end

   assign bus.ReadData = w_rdata;
   assign bus.Hit      = w_hit;
   assign PortOut      = r_portout;
   assign Irq          = (r_status[STS_CHG]   & r_ctrl.ie_chg) |
                         (r_status[STS_MATCH] & r_ctrl.ie_match);

endmodule
